serial_subtractor8: RTL and testbench

- Bit-serial 8-bit subtractor computing Di = Xi - Yi - B0 over 8 clock cycles, LSB first, one full-subtractor cell.
- Reverse-direction companion to the 8-bit hybrid adder; used where subtraction is needed at minimal gate count and multi-cycle latency is acceptable.
- Accepts operands on a start pulse and returns difference, borrow-out and status flags with a one-cycle done strobe.

---
 rtl/serial_subtractor8.sv | 165 ++++++++++++++++
 tb/tb_serial_subtractor8.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor8.sv
// Bit-serial subtractor: one full-subtractor cell walks the operands LSB
// first and produces difference, borrow-out, overflow and zero flags.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   start request, sampled only when not busy
//   Xi    minuend, latched on accepted start
//   Yi    subtrahend, latched on accepted start
//   B0    borrow-in, latched on accepted start
//   Di    registered difference
//   B8    unsigned borrow-out
//   V     signed overflow of X - Y
//   Z     difference is zero
//   busy  high while bits are being processed
//   done  one-cycle strobe when results update
module serial_subtractor8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Xi,
    input  logic [WIDTH-1:0] Yi,
    input  logic             B0,
    output logic [WIDTH-1:0] Di,
    output logic             B8,
    output logic             V,
    output logic             Z,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             xm_q, xm_d;
    logic             ym_q, ym_d;
    logic [WIDTH-1:0] di_q, di_d;
    logic             b8_q, b8_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full-subtractor cell on the current LSBs
    logic             bit_d;
    logic             brw_nx;
    logic [WIDTH-1:0] acc_nx;

    always_comb begin
        bit_d  = xs_q[0] ^ ys_q[0] ^ brw_q;
        brw_nx = (~xs_q[0] & ys_q[0])
               | (~(xs_q[0] ^ ys_q[0]) & brw_q);
        // Difference bits enter at the MSB and slide down,
        // so after WIDTH shifts bit 0 sits at position 0.
        acc_nx = {bit_d, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        acc_d   = acc_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        xm_d    = xm_q;
        ym_d    = ym_q;
        di_d    = di_q;
        b8_d    = b8_q;
        v_d     = v_q;
        z_d     = z_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_RUN: begin
                acc_d = acc_nx;
                brw_d = brw_nx;
                xs_d  = {1'b0, xs_q[WIDTH-1:1]};
                ys_d  = {1'b0, ys_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    di_d    = acc_nx;
                    b8_d    = brw_nx;
                    // bit_d is the result MSB on the final step
                    v_d     = (xm_q != ym_q) && (bit_d != xm_q);
                    z_d     = (acc_nx == '0);
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request;
                // from DONE this gives back-to-back operation.
                if (start) begin
                    xs_d    = Xi;
                    ys_d    = Yi;
                    brw_d   = B0;
                    xm_d    = Xi[WIDTH-1];
                    ym_d    = Yi[WIDTH-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            acc_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            xm_q    <= 1'b0;
            ym_q    <= 1'b0;
            di_q    <= '0;
            b8_q    <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            acc_q   <= acc_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            di_q    <= di_d;
            b8_q    <= b8_d;
            v_q     <= v_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Di   = di_q;
    assign B8   = b8_q;
    assign V    = v_q;
    assign Z    = z_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor8.sv
// Self-checking bench for serial_subtractor8: vector table, corner
// sequences and randomized operands against an arithmetic model.
module tb_serial_subtractor8;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x_i;
    logic [7:0] y_i;
    logic       b_i;
    logic [7:0] d_o;
    logic       b8_o;
    logic       v_o;
    logic       z_o;
    logic       busy_o;
    logic       done_o;

    int checks;
    int errors;

    serial_subtractor8 #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .Xi   (x_i),
        .Yi   (y_i),
        .B0   (b_i),
        .Di   (d_o),
        .B8   (b8_o),
        .V    (v_o),
        .Z    (z_o),
        .busy (busy_o),
        .done (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       b;
        logic [7:0] d;
        logic       b8;
        logic       v;
        logic       z;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain 9-bit arithmetic
    task automatic model(input logic [7:0] x, input logic [7:0] y,
                         input logic b, output logic [7:0] d,
                         output logic b8, output logic v,
                         output logic z);
        logic [8:0] full;
        full = {1'b0, x} - {1'b0, y} - {8'd0, b};
        d  = full[7:0];
        b8 = full[8];
        v  = (x[7] != y[7]) && (d[7] != x[7]);
        z  = (d == 8'd0);
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input logic b, input logic [7:0] ed,
                          input logic eb8, input logic ev,
                          input logic ez, input string nm);
        logic [7:0] prev;
        int lat;
        logic got;
        logic hold_ok;
        prev = d_o;
        @(negedge clk);
        x_i = x; y_i = y; b_i = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x_i = 8'($urandom); y_i = 8'($urandom); b_i = 1'($urandom);
        chk({nm, " busy_after_accept"}, 32'(busy_o), 32'd1);
        lat = 0; got = 1'b0; hold_ok = 1'b1;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk); #1;
            lat = i;
            if (done_o) got = 1'b1;
            else if (!busy_o || d_o !== prev) hold_ok = 1'b0;
        end
        chk({nm, " latency"}, 32'(lat), 32'd8);
        chk({nm, " busy_hold"}, 32'(hold_ok), 32'd1);
        chk({nm, " Di"}, 32'(d_o), 32'(ed));
        chk({nm, " B8"}, 32'(b8_o), 32'(eb8));
        chk({nm, " V"}, 32'(v_o), 32'(ev));
        chk({nm, " Z"}, 32'(z_o), 32'(ez));
        chk({nm, " busy_done"}, 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        chk({nm, " done_drop"}, 32'(done_o), 32'd0);
    endtask

    vec_t tbl[9];

    initial begin
        logic [7:0] ed;
        logic eb8, ev, ez;
        int ndone;
        int last_t;
        logic ok;

        checks = 0; errors = 0;
        tbl[0] = '{8'h5A, 8'h21, 1'b0, 8'h39, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{8'h40, 8'h01, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0;
        x_i = 8'h00; y_i = 8'h00; b_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset Di", 32'(d_o), 32'd0);
        chk("reset flags", {28'd0, b8_o, v_o, z_o, busy_o}, 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i])
            run_op(tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].d,
                   tbl[i].b8, tbl[i].v, tbl[i].z,
                   $sformatf("vec%0d", i));

        // start while busy is ignored
        @(negedge clk);
        x_i = 8'h40; y_i = 8'h01; b_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; last_t = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                @(negedge clk);
                x_i = 8'hFF; y_i = 8'hFF; start = 1'b1;
            end
            if (i == 4) begin
                @(negedge clk);
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done_o) begin ndone++; last_t = i; end
        end
        chk("ignore ndone", 32'(ndone), 32'd1);
        chk("ignore time", 32'(last_t), 32'd8);
        chk("ignore Di", 32'(d_o), 32'h3F);
        chk("ignore idle", 32'(busy_o), 32'd0);

        // start held high: back-to-back every 9 cycles
        @(negedge clk);
        x_i = 8'h05; y_i = 8'h03; b_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        ndone = 0; last_t = 0; ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (busy_o === done_o) ok = 1'b0;
            if (done_o) begin
                ndone++;
                chk("b2b interval", 32'(i - last_t),
                    (ndone == 1) ? 32'd8 : 32'd9);
                chk("b2b Di", 32'(d_o), 32'h02);
                last_t = i;
            end
        end
        chk("b2b ndone", 32'(ndone), 32'd4);
        chk("b2b busy", 32'(ok), 32'd1);
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(posedge clk); #1;
            if (done_o) ok = 1'b1;
        end
        chk("b2b drain", 32'(ok), 32'd1);
        @(posedge clk); #1;

        // reset in the middle of an operation
        @(negedge clk);
        x_i = 8'h5A; y_i = 8'h21; b_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst Di", 32'(d_o), 32'd0);
        chk("midrst flags", {28'd0, b8_o, v_o, z_o, busy_o}, 32'd0);
        chk("midrst done", 32'(done_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_o || busy_o) ok = 1'b0;
        end
        chk("midrst quiet", 32'(ok), 32'd1);
        run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, "post_rst");

        // randomized operands against the model
        for (int n = 0; n < 40; n++) begin
            logic [7:0] rx, ry;
            logic rb;
            rx = 8'($urandom);
            ry = 8'($urandom);
            rb = 1'($urandom);
            if (n % 8 == 0) ry = rx;
            model(rx, ry, rb, ed, eb8, ev, ez);
            run_op(rx, ry, rb, ed, eb8, ev, ez,
                   $sformatf("rnd%0d_%02h_%02h_%0d", n, rx, ry, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
